// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronize, deglitch, decode to a signed position count.
// Optional velocity window measurement enabled by defining QUAD_DECODER_VELOCITY_EN.
module quad_decoder #(
  parameter int COUNT_W  = 32,
  parameter int FILT_LEN = 4,
  parameter int WIN_CYC  = 50000,
  parameter int VEL_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_in,
  input  logic                      b_in,
  input  logic                      clear,
  output logic signed [COUNT_W-1:0] count,
  output logic                      dir,
  output logic                      err,
  output logic signed [VEL_W-1:0]   vel,
  output logic                      vel_valid
);

  localparam logic [7:0] FILT_MAX = 8'(FILT_LEN - 1);

  logic [1:0] raw;
  logic [1:0] filt;
  logic [1:0] prev_reg;
  logic       step_up;
  logic       step_dn;
  logic       illegal;

  assign raw = {a_in, b_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic       sync1_reg;
      logic       sync2_reg;
      logic       level_reg;
      logic [7:0] fcnt_reg;

      // A new level is accepted only after FILT_LEN consecutive disagreeing samples.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          fcnt_reg  <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != level_reg) begin
            if (fcnt_reg == FILT_MAX) begin
              level_reg <= sync2_reg;
              fcnt_reg  <= '0;
            end else begin
              fcnt_reg  <= fcnt_reg + 8'd1;
            end
          end else begin
            fcnt_reg <= '0;
          end
        end
      end

      assign filt[gi] = level_reg;
    end
  endgenerate

  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    case ({prev_reg, filt})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_dn = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
      default: ;
    endcase
  end

  // Count wraps naturally modulo 2^COUNT_W; clear wins over any decoded event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg <= 2'b00;
      count    <= '0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else begin
      prev_reg <= filt;
      if (clear) begin
        count <= '0;
        err   <= 1'b0;
      end else if (step_up) begin
        count <= count + COUNT_W'(1);
        dir   <= 1'b1;
      end else if (step_dn) begin
        count <= count - COUNT_W'(1);
        dir   <= 1'b0;
      end else if (illegal) begin
        err   <= 1'b1;
      end
    end
  end

`ifdef QUAD_DECODER_VELOCITY_EN
  localparam int                WIN_W    = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1;
  localparam int                ACC_W    = WIN_W + 2;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam longint            VEL_MAX  = (longint'(1) <<< (VEL_W - 1)) - 1;
  localparam longint            VEL_MIN  = -VEL_MAX - 1;

  logic        [WIN_W-1:0] win_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [VEL_W-1:0] vel_sat;
  longint                  acc_wide;

  always_comb begin
    acc_next = acc_reg;
    if (step_up) begin
      acc_next = acc_reg + ACC_W'(1);
    end else if (step_dn) begin
      acc_next = acc_reg - ACC_W'(1);
    end
    acc_wide = longint'(acc_next);
    vel_sat  = VEL_W'(acc_wide);
    if (acc_wide > VEL_MAX) begin
      vel_sat = VEL_W'(VEL_MAX);
    end else if (acc_wide < VEL_MIN) begin
      vel_sat = VEL_W'(VEL_MIN);
    end
  end

  // The final window cycle publishes the net steps including that cycle's own step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_reg   <= '0;
      acc_reg   <= '0;
      vel       <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (clear) begin
        win_reg <= '0;
        acc_reg <= '0;
      end else if (win_reg == WIN_LAST) begin
        win_reg   <= '0;
        acc_reg   <= '0;
        vel       <= vel_sat;
        vel_valid <= 1'b1;
      end else begin
        win_reg <= win_reg + WIN_W'(1);
        acc_reg <= acc_next;
      end
    end
  end
`else
  logic unused_win;
  assign unused_win = ^WIN_CYC;
  assign vel        = '0;
  assign vel_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: latency, glitch filter, wrap, illegal/clear, async reset,
// and the velocity window when QUAD_DECODER_VELOCITY_EN is defined.
module tb_quad_decoder;

  logic       clk;
  logic       reset;
  logic       a_in;
  logic       b_in;
  logic       clear;
  logic [7:0] count;
  logic       dir;
  logic       err;
  logic [3:0] vel;
  logic       vel_valid;
  logic [1:0] q;
  int         total;
  int         bad;

  quad_decoder #(
    .COUNT_W (8),
    .FILT_LEN(4),
    .WIN_CYC (1000),
    .VEL_W   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a_in     (a_in),
    .b_in     (b_in),
    .clear    (clear),
    .count    (count),
    .dir      (dir),
    .err      (err),
    .vel      (vel),
    .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s val=%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One quadrature step from the current bench state; cw order is 00->10->11->01->00.
  task automatic step(input logic cw, input int hold);
    logic [1:0] n;
    case (q)
      2'b00:   n = cw ? 2'b10 : 2'b01;
      2'b10:   n = cw ? 2'b11 : 2'b00;
      2'b11:   n = cw ? 2'b01 : 2'b10;
      default: n = cw ? 2'b00 : 2'b11;
    endcase
    q    = n;
    a_in = q[1];
    b_in = q[0];
    tick(hold);
  endtask

  task automatic wait_valid(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      tick(1);
      if (vel_valid) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    reset = 1'b1;
    a_in  = 1'b0;
    b_in  = 1'b0;
    clear = 1'b0;
    q     = 2'b00;
    tick(3);
    check("rst_count", 32'(count), 32'h0);
    check("rst_dir", 32'(dir), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_vel", 32'(vel), 32'h0);
    check("rst_valid", 32'(vel_valid), 32'h0);
    reset = 1'b0;
    tick(5);

    // First step latency: count must move on edge 7, not edge 6.
    q    = 2'b10;
    a_in = 1'b1;
    tick(6);
    check("lat_edge6", 32'(count), 32'h0);
    tick(1);
    check("lat_edge7", 32'(count), 32'h1);
    check("lat_dir", 32'(dir), 32'h1);
    tick(13);

    repeat (15) step(1'b1, 20);
    check("cw16_count", 32'(count), 32'd16);
    check("cw16_dir", 32'(dir), 32'h1);
    check("cw16_err", 32'(err), 32'h0);
    repeat (16) step(1'b0, 20);
    check("ccw16_count", 32'(count), 32'h0);
    check("ccw16_dir", 32'(dir), 32'h0);

    // 3-cycle glitch is rejected; 4-cycle pulse is accepted both ways.
    a_in = 1'b1;
    tick(3);
    a_in = 1'b0;
    tick(12);
    check("glitch3", 32'(count), 32'h0);
    a_in = 1'b1;
    tick(4);
    a_in = 1'b0;
    tick(2);
    check("pulse4_edge6", 32'(count), 32'h0);
    tick(1);
    check("pulse4_edge7", 32'(count), 32'h1);
    tick(10);
    check("pulse4_back", 32'(count), 32'h0);
    check("pulse4_dir", 32'(dir), 32'h0);

    // Wrap boundaries.
    step(1'b0, 10);
    check("wrap_under", 32'(count), 32'hFF);
    step(1'b1, 10);
    check("wrap_zero", 32'(count), 32'h0);
    repeat (127) step(1'b1, 10);
    check("wrap_max", 32'(count), 32'h7F);
    step(1'b1, 10);
    check("wrap_over", 32'(count), 32'h80);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_count", 32'(count), 32'h0);
    check("clr_dir_hold", 32'(dir), 32'h1);
    tick(2);

    // Both channels flip together: illegal.
    q    = 2'b11;
    a_in = 1'b1;
    b_in = 1'b1;
    tick(10);
    check("ill_err", 32'(err), 32'h1);
    check("ill_count", 32'(count), 32'h0);

    // clear coincides with the decode edge of a CW step.
    q    = 2'b01;
    a_in = 1'b0;
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clrstep_count", 32'(count), 32'h0);
    check("clrstep_err", 32'(err), 32'h0);
    tick(5);
    step(1'b1, 10);
    check("after_clr", 32'(count), 32'h1);

    // Asynchronous reset mid-cycle.
    repeat (4) step(1'b1, 10);
    check("pre_rst", 32'(count), 32'h5);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'h0);
    check("arst_dir", 32'(dir), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    check("arst_vel", 32'(vel), 32'h0);
    check("arst_valid", 32'(vel_valid), 32'h0);
    q    = 2'b11;
    a_in = 1'b1;
    b_in = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    check("rst11_err", 32'(err), 32'h1);
    check("rst11_count", 32'(count), 32'h0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("rst11_clr", 32'(err), 32'h0);

`ifdef QUAD_DECODER_VELOCITY_EN
    // The clear above restarted the window; 12 CW steps saturate a 4-bit vel.
    repeat (12) step(1'b1, 10);
    check("vel_cnt12", 32'(count), 32'd12);
    wait_valid("vel_pulse1");
    check("vel_sat", 32'(vel), 32'h7);
    tick(1);
    check("vel_once", 32'(vel_valid), 32'h0);
    repeat (3) step(1'b0, 10);
    wait_valid("vel_pulse2");
    check("vel_neg3", 32'(vel), 32'hD);
    check("vel_cnt9", 32'(count), 32'd9);
`else
    tick(50);
    check("vel_off", 32'(vel), 32'h0);
    check("valid_off", 32'(vel_valid), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
